// File: rtl/btb_update_unit.sv
// btb_update_unit: tracks in-flight fetch predictions, resolves the oldest against execute,
// raises mispredict/redirect and drives the BTB write port.
module btb_update_unit #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push_valid,
   input  logic [31:0]   i_push_pc,
   input  logic          i_push_pred_taken,
   input  logic [29:0]   i_push_pred_tgt,
   input  logic          i_resolve_valid,
   input  logic          i_resolve_is_br,
   input  logic          i_resolve_taken,
   input  logic [29:0]   i_resolve_tgt,
   output logic          o_btb_wen,
   output logic [1:0]    o_btb_wsel,
   output logic [27:0]   o_btb_tag,
   output logic [29:0]   o_btb_target,
   output logic          o_btb_active,
   output logic          o_mispredict,
   output logic [31:0]   o_redirect_pc,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count,
   output logic          o_overflow
);
   logic [29:0] r_pc   [DEPTH];
   logic        r_pt   [DEPTH];
   logic [29:0] r_ptgt [DEPTH];
   logic [AW:0] r_wp, r_rp;
   logic [29:0] w_hpc, w_htgt;
   logic        w_hpt, w_pop, w_push, w_mis_tk, w_mis_ev, w_mis, w_unused;

   assign w_unused = ^i_push_pc[1:0];
   assign o_empty  = r_wp == r_rp;
   assign o_full   = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
   assign o_count  = r_wp - r_rp;
   assign w_hpc    = r_pc[r_rp[AW-1:0]];
   assign w_hpt    = r_pt[r_rp[AW-1:0]];
   assign w_htgt   = r_ptgt[r_rp[AW-1:0]];
   assign w_pop    = i_resolve_valid & !o_empty;
   // Taken branch whose target was not (correctly) predicted installs; any other predicted-taken miss evicts.
   assign w_mis_tk = i_resolve_is_br & i_resolve_taken & (!w_hpt | (w_htgt != i_resolve_tgt));
   assign w_mis_ev = w_hpt & !(i_resolve_is_br & i_resolve_taken);
   assign w_mis    = w_pop & (w_mis_tk | w_mis_ev);
   // A push on a mispredict cycle is wrong-path and silently dropped.
   assign w_push   = i_push_valid & (!o_full | w_pop) & !w_mis;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wp[AW-1:0]]   <= i_push_pc[31:2];
         r_pt[r_wp[AW-1:0]]   <= i_push_pred_taken;
         r_ptgt[r_wp[AW-1:0]] <= i_push_pred_tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp          <= '0;
         r_rp          <= '0;
         o_overflow    <= 1'b0;
         o_btb_wen     <= 1'b0;
         o_mispredict  <= 1'b0;
         o_btb_wsel    <= '0;
         o_btb_tag     <= '0;
         o_btb_target  <= '0;
         o_btb_active  <= 1'b0;
         o_redirect_pc <= '0;
      end else begin
         r_wp         <= r_wp + (AW+1)'(w_push);
         r_rp         <= w_mis ? r_wp : r_rp + (AW+1)'(w_pop);
         o_overflow   <= o_overflow | (i_push_valid & o_full & !w_pop);
         o_btb_wen    <= w_mis;
         o_mispredict <= w_mis;
         if (w_mis) begin
            o_btb_wsel    <= w_hpc[1:0];
            o_btb_tag     <= w_hpc[29:2];
            o_btb_target  <= w_mis_tk ? i_resolve_tgt : 30'd0;
            o_btb_active  <= w_mis_tk;
            o_redirect_pc <= w_mis_tk ? {i_resolve_tgt, 2'b00} : {w_hpc + 30'd1, 2'b00};
         end
      end
   end
endmodule

// File: tb/tb_btb_update_unit.sv
// tb_btb_update_unit: directed stimulus against a queue-based prediction model,
// checked every cycle plus hand-computed literal expectations.
module tb_btb_update_unit;
   localparam int DEPTH = 4;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        pv = 1'b0, ppt = 1'b0, rv = 1'b0, br = 1'b0, tk = 1'b0;
   logic [31:0] ppc = '0;
   logic [29:0] ptg = '0, rtg = '0;
   logic        wen, act, mis, full, empty, ovf;
   logic [1:0]  wsel;
   logic [27:0] tag;
   logic [29:0] tgt;
   logic [31:0] red;
   logic [2:0]  cnt;
   int n_tests = 0, n_fail = 0;

   typedef struct {logic [31:0] pc; logic pt; logic [29:0] tgt;} ent_t;
   ent_t mq[$];
   logic        e_wen = 0, e_mis = 0, e_act = 0, e_ovf = 0;
   logic [1:0]  e_wsel = 0;
   logic [27:0] e_tag = 0;
   logic [29:0] e_tgt = 0;
   logic [31:0] e_red = 0;
   int          e_cnt = 0;

   btb_update_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .i_push_valid(pv), .i_push_pc(ppc), .i_push_pred_taken(ppt),
      .i_push_pred_tgt(ptg), .i_resolve_valid(rv), .i_resolve_is_br(br), .i_resolve_taken(tk),
      .i_resolve_tgt(rtg), .o_btb_wen(wen), .o_btb_wsel(wsel), .o_btb_tag(tag),
      .o_btb_target(tgt), .o_btb_active(act), .o_mispredict(mis), .o_redirect_pc(red),
      .o_full(full), .o_empty(empty), .o_count(cnt), .o_overflow(ovf));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("count", 32'(cnt), 32'(e_cnt));
      chk("empty", 32'(empty), 32'(e_cnt == 0));
      chk("full", 32'(full), 32'(e_cnt == DEPTH));
      chk("wen", 32'(wen), 32'(e_wen));
      chk("mispredict", 32'(mis), 32'(e_mis));
      chk("overflow", 32'(ovf), 32'(e_ovf));
      chk("wsel", 32'(wsel), 32'(e_wsel));
      chk("tag", 32'(tag), 32'(e_tag));
      chk("target", 32'(tgt), 32'(e_tgt));
      chk("active", 32'(act), 32'(e_act));
      chk("redirect", red, e_red);
   end

   task automatic cyc(input logic pv_, input logic [31:0] ppc_, input logic ppt_, input logic [29:0] ptg_,
                      input logic rv_, input logic br_, input logic tk_, input logic [29:0] rtg_);
      logic n_mis, n_act, n_ovf, popd;
      logic [1:0] n_wsel;
      logic [27:0] n_tag;
      logic [29:0] n_tgt;
      logic [31:0] n_red;
      ent_t h;
      pv = pv_; ppc = ppc_; ppt = ppt_; ptg = ptg_; rv = rv_; br = br_; tk = tk_; rtg = rtg_;
      n_mis = 0; n_act = e_act; n_ovf = e_ovf; n_wsel = e_wsel; n_tag = e_tag; n_tgt = e_tgt; n_red = e_red;
      popd = rv_ && mq.size() > 0;
      if (popd) begin
         h = mq[0];
         if (br_ && tk_ && (!h.pt || h.tgt != rtg_)) begin
            n_mis = 1; n_act = 1; n_tgt = rtg_; n_red = {rtg_, 2'b00};
         end else if (h.pt && !(br_ && tk_)) begin
            n_mis = 1; n_act = 0; n_tgt = 0; n_red = h.pc + 32'd4;
         end
         if (n_mis) begin n_wsel = h.pc[3:2]; n_tag = h.pc[31:4]; end
      end
      if (n_mis) mq.delete();
      else begin
         if (pv_ && mq.size() == DEPTH && !popd) n_ovf = 1;
         if (popd) void'(mq.pop_front());
         if (pv_ && mq.size() < DEPTH) mq.push_back('{pc: ppc_, pt: ppt_, tgt: ptg_});
      end
      @(posedge clk);
      e_wen = n_mis; e_mis = n_mis; e_act = n_act; e_ovf = n_ovf; e_wsel = n_wsel;
      e_tag = n_tag; e_tgt = n_tgt; e_red = n_red; e_cnt = mq.size();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc_, input logic pt_, input logic [29:0] t_);
      cyc(1, pc_, pt_, t_, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic br_, input logic tk_, input logic [29:0] t_);
      cyc(0, 0, 0, 0, 1, br_, tk_, t_);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 0; pv = 1; ppc = 32'h44; rv = 0;
      mq.delete();
      e_wen = 0; e_mis = 0; e_act = 0; e_ovf = 0; e_wsel = 0; e_tag = 0; e_tgt = 0; e_red = 0; e_cnt = 0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1; pv = 0;
   endtask

   initial begin
      do_reset();
      chk("rst count", 32'(cnt), 0);
      chk("rst empty", 32'(empty), 1);
      chk("rst wen", 32'(wen), 0);
      chk("rst mis", 32'(mis), 0);
      chk("rst ovf", 32'(ovf), 0);
      // taken branch, predicted not-taken: install
      push(32'h104, 0, 0);
      resolve(1, 1, 30'h40);
      chk("t1 wen", 32'(wen), 1);
      chk("t1 wsel", 32'(wsel), 1);
      chk("t1 tag", 32'(tag), 32'h10);
      chk("t1 target", 32'(tgt), 32'h40);
      chk("t1 active", 32'(act), 1);
      chk("t1 mis", 32'(mis), 1);
      chk("t1 redirect", red, 32'h100);
      chk("t1 empty", 32'(empty), 1);
      resolve(1, 1, 30'h7);
      chk("pulse wen", 32'(wen), 0);
      chk("hold redirect", red, 32'h100);
      // correct taken prediction
      push(32'h208, 1, 30'h90);
      resolve(1, 1, 30'h90);
      chk("t2 wen", 32'(wen), 0);
      chk("t2 mis", 32'(mis), 0);
      // predicted taken, actually not taken: evict
      push(32'h20C, 1, 30'h55);
      resolve(1, 0, 0);
      chk("t3 wen", 32'(wen), 1);
      chk("t3 active", 32'(act), 0);
      chk("t3 wsel", 32'(wsel), 3);
      chk("t3 target", 32'(tgt), 0);
      chk("t3 redirect", red, 32'h210);
      // fill, overflow, push+pop at full, drain
      for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 1, 30'h11 + 30'(i));
      push(32'h310, 1, 30'h15);
      chk("t4 full", 32'(full), 1);
      chk("t4 count", 32'(cnt), 4);
      chk("t4 ovf", 32'(ovf), 1);
      cyc(1, 32'h600, 1, 30'h16, 1, 1, 1, 30'h11);
      chk("t4 pp count", 32'(cnt), 4);
      chk("t4 pp wen", 32'(wen), 0);
      resolve(1, 1, 30'h12);
      resolve(1, 1, 30'h13);
      resolve(1, 1, 30'h14);
      resolve(1, 1, 30'h16);
      chk("t4 drain wen", 32'(wen), 0);
      chk("t4 drain empty", 32'(empty), 1);
      // push+pop on an empty queue: push lands
      cyc(1, 32'h800, 0, 0, 1, 0, 0, 0);
      chk("t5 count", 32'(cnt), 1);
      resolve(0, 0, 0);
      chk("t5 wen", 32'(wen), 0);
      // squash with a same-cycle push
      do_reset();
      for (int i = 0; i < 3; i++) push(32'h700 + 32'(4 * i), 0, 0);
      cyc(1, 32'h70C, 0, 0, 1, 1, 1, 30'h80);
      chk("t6 empty", 32'(empty), 1);
      chk("t6 count", 32'(cnt), 0);
      chk("t6 ovf", 32'(ovf), 0);
      chk("t6 mis", 32'(mis), 1);
      chk("t6 redirect", red, 32'h200);
      push(32'hFFFF_FFFC, 1, 30'h3);
      chk("t6 push count", 32'(cnt), 1);
      resolve(0, 0, 0);
      chk("t7 redirect", red, 32'h0);
      chk("t7 wen", 32'(wen), 1);
      chk("t7 active", 32'(act), 0);
      chk("t7 wsel", 32'(wsel), 3);
      chk("t7 tag", 32'(tag), 32'hFFF_FFFF);
      resolve(1, 1, 30'h9);
      chk("t8 idle wen", 32'(wen), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
